enable_sequencer: RTL and testbench
===================================

# enable_sequencer

Staged enable sequencer that sits directly downstream of the power-up delay-enable stage. It takes the single delayed enable level and releases a thermometer-coded bank of per-stage enables one stage every GAP cycles. When the enable drops, it withdraws the stages in reverse order at the same spacing. An abort input forces an immediate full shutdown and locks out restart until the enable has been seen low.

## Interface
- STAGES, default 4, number of stage enables; legal 1..16
- GAP, default 8, cycles between successive stage changes; legal 1..2^16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en_in  input  1  level enable from the upstream delay-enable stage; sampled every clk edge
- abort  input  1  synchronous shutdown request; highest priority after rst
- stage_en  output  STAGES  thermometer enables; bit i is asserted only if bits 0..i-1 are asserted
- busy  output  1  high in UP or DOWN
- done  output  1  high in ON (all stages asserted)
- fault  output  1  high in FAULT (abort lockout)

## Operation
- Internal level L ranges 0..STAGES. stage_en[i] = (i < L). All outputs are registered.
- Gap counter cnt has width max(1, clog2(GAP)). It is cleared on every L change and on every state change.
- States are IDLE, UP, ON, DOWN and FAULT. Each row below gives conditions in priority order, evaluated at each clk edge.
- Any state, abort=1: L=0, cnt=0, go to FAULT.
- IDLE (L=0):
  - en_in=1: L=1; go to ON if STAGES=1, else go to UP.
- UP:
  - en_in=0: L=L-1; go to IDLE if L becomes 0, else go to DOWN.
  - Else if cnt==GAP-1: L=L+1; go to ON if L reaches STAGES.
  - Else cnt=cnt+1.
- ON:
  - en_in=0: L=STAGES-1; go to IDLE if L becomes 0, else go to DOWN.
- DOWN:
  - en_in=1: L=L+1; go to ON if L reaches STAGES, else go to UP.
  - Else if cnt==GAP-1: L=L-1; go to IDLE if L reaches 0.
  - Else cnt=cnt+1.
- FAULT:
  - L is held at 0.
  - en_in=0 and abort=0: go to IDLE.
  - Otherwise stay in FAULT, even if en_in is held high.
- A direction reversal, either UP to DOWN or DOWN to UP, takes effect on the same edge that samples the new en_in. The first step happens immediately; later steps follow at GAP spacing.
- L never exceeds STAGES and never goes below 0. No wrap-around is possible.

## Timing
- Reset state (rst=1, asynchronous): state=IDLE, L=0, cnt=0, stage_en=0, busy=0, done=0, fault=0.
- Reset released mid-sequence: the block restarts from IDLE. If en_in is still high, stage_en[0] asserts on the first edge after reset deasserts.
- en_in sampled high at edge t (from IDLE): stage_en[0] is high after edge t. Bit k is high after edge t+k*GAP.
- done rises on the same edge as stage_en[STAGES-1]. Full ramp latency is (STAGES-1)*GAP+1 edges.
- en_in sampled low at edge t (from ON): stage_en[STAGES-1] clears after edge t. Bit k clears after edge t+(STAGES-1-k)*GAP.
- busy stays high from the first step up to the last step down, excluding ON.
- With GAP=1 the level changes by one every edge.
- abort asserted at edge t: stage_en=0 and fault=1 after edge t.
- Exit from FAULT: fault clears on the first edge that samples en_in=0 and abort=0. The next en_in=1 restarts the ramp normally.
- Simultaneous abort and en_in transitions: abort wins.
- Simultaneous en_in drop and GAP expiry in UP: the decrement wins, and no increment occurs.

## Test plan
- Reset check: STAGES=4, GAP=3; assert rst mid-ramp with stage_en=0011. Required: all outputs 0 immediately (asynchronous), without waiting for a clk edge.
- Full ramp-up: STAGES=4, GAP=3; en_in rises and is sampled at edge 0. Required: stage_en=0001 after edge 0, 0011 after edge 3, 0111 after edge 6, 1111 after edge 9. done=1 after edge 9. busy=1 after edges 0..8.
- Full ramp-down: from ON, en_in is sampled low at edge 20. Required: stage_en=0111 after edge 20, 0011 after edge 23, 0001 after edge 26, 0000 after edge 29. state=IDLE and busy=0 after edge 29.
- Reversal: en_in drops at edge 4, while stage_en=0011. Required: 0001 after edge 4. en_in then rises at edge 5. Required: 0011 after edge 5 and 0111 after edge 8.
- Abort: during UP with stage_en=0011, abort=1 for one edge while en_in stays high. Required: stage_en=0000 and fault=1, held for 10+ cycles. en_in then goes low. Required: fault=0 one edge later. en_in then goes high again. Required: stage_en=0001 on the next edge.
- Degenerate parameters, STAGES=1, GAP=1: en_in toggles 1,1,0,1. Required: stage_en=1,1,0,1 and done=stage_en after each edge; busy stays 0 throughout.

Source files
------------

// File: rtl/enable_sequencer_if.sv
// Enable-sequencer signal bundle: upstream enable/abort in, staged enables and status out.
interface enable_sequencer_if #(
  parameter int STAGES = 4
);
  logic              en_in;
  logic              abort;
  logic [STAGES-1:0] stage_en;
  logic              busy;
  logic              done;
  logic              fault;

  modport master (
    output en_in, abort,
    input  stage_en, busy, done, fault
  );

  modport slave (
    input  en_in, abort,
    output stage_en, busy, done, fault
  );
endinterface

// File: rtl/enable_sequencer.sv
// Staged enable sequencer: ramps a thermometer bank of enables up/down one stage per GAP
// cycles, with an abort that forces shutdown and locks out restart until en_in is seen low.
module enable_sequencer #(
  parameter int STAGES = 4,
  parameter int GAP    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  enable_sequencer_if.slave    bus
);
  localparam int LW = $clog2(STAGES + 1);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UP    = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [LW-1:0] L_FULL = LW'(STAGES);
  localparam logic [LW-1:0] L_TOP  = LW'(STAGES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(GAP - 1);

  logic [2:0]        state_q, state_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [STAGES-1:0] stage_en_q;
  logic              busy_q, done_q, fault_q;

  function automatic logic [STAGES-1:0] thermo(input logic [LW-1:0] lvl);
    logic [STAGES-1:0] th;
    for (int i = 0; i < STAGES; i++) th[i] = (LW'(i) < lvl);
    return th;
  endfunction

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = S_FAULT;
      lvl_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.en_in) begin
            lvl_d   = L_ONE;
            cnt_d   = '0;
            state_d = (STAGES == 1) ? S_ON : S_UP;
          end
        end
        S_UP: begin
          // A drop of en_in beats a simultaneous gap expiry: step down, never up.
          if (!bus.en_in) begin
            lvl_d   = lvl_q - L_ONE;
            cnt_d   = '0;
            state_d = (lvl_q == L_ONE) ? S_IDLE : S_DOWN;
          end else if (cnt_q == C_LAST) begin
            lvl_d   = lvl_q + L_ONE;
            cnt_d   = '0;
            if (lvl_q + L_ONE == L_FULL) state_d = S_ON;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ON: begin
          if (!bus.en_in) begin
            lvl_d   = L_TOP;
            cnt_d   = '0;
            state_d = (STAGES == 1) ? S_IDLE : S_DOWN;
          end
        end
        S_DOWN: begin
          if (bus.en_in) begin
            lvl_d   = lvl_q + L_ONE;
            cnt_d   = '0;
            state_d = (lvl_q + L_ONE == L_FULL) ? S_ON : S_UP;
          end else if (cnt_q == C_LAST) begin
            lvl_d   = lvl_q - L_ONE;
            cnt_d   = '0;
            if (lvl_q == L_ONE) state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FAULT: begin
          lvl_d = '0;
          cnt_d = '0;
          if (!bus.en_in) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          lvl_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state so they line up with the level on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lvl_q      <= '0;
      cnt_q      <= '0;
      stage_en_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      cnt_q      <= cnt_d;
      stage_en_q <= thermo(lvl_d);
      busy_q     <= (state_d == S_UP) || (state_d == S_DOWN);
      done_q     <= (state_d == S_ON);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign bus.stage_en = stage_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fault    = fault_q;
endmodule

// File: tb/tb_enable_sequencer.sv
// Scoreboard bench for enable_sequencer: directed steps push expected outputs, a monitor checks them.
module tb_enable_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enable_sequencer_if #(.STAGES(4)) ifa ();
  enable_sequencer_if #(.STAGES(1)) ifb ();

  enable_sequencer #(.STAGES(4), .GAP(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  enable_sequencer #(.STAGES(1), .GAP(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic       sel;
    logic [3:0] stg;
    logic       busy;
    logic       done;
    logic       fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  function automatic logic [6:0] actual(input logic sel);
    if (sel) return {3'b000, ifb.stage_en, ifb.busy, ifb.done, ifb.fault};
    return {ifa.stage_en, ifa.busy, ifa.done, ifa.fault};
  endfunction

  // Monitor: pops one expectation per edge the driver scheduled.
  initial begin : monitor
    exp_t e;
    logic [6:0] got, want;
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e    = exp_q.pop_front();
        got  = actual(e.sel);
        want = {e.stg, e.busy, e.done, e.fault};
        n++;
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL edge%0d dut%0d {stage_en,busy,done,fault} got=%b want=%b",
                   n, e.sel, got, want);
        end
      end
    end
  end

  task automatic step(input logic sel, input logic en, input logic ab,
                      input logic [3:0] stg, input logic bsy, input logic dn, input logic flt);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      ifb.en_in = en;
      ifb.abort = ab;
    end else begin
      ifa.en_in = en;
      ifa.abort = ab;
    end
    e = '{sel: sel, stg: stg, busy: bsy, done: dn, fault: flt};
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic steps(input int n, input logic sel, input logic en, input logic ab,
                       input logic [3:0] stg, input logic bsy, input logic dn, input logic flt);
    for (int i = 0; i < n; i++) step(sel, en, ab, stg, bsy, dn, flt);
  endtask

  task automatic direct_check(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin : driver
    int budget;
    ifa.en_in = 1'b0; ifa.abort = 1'b0;
    ifb.en_in = 1'b0; ifb.abort = 1'b0;
    #12;
    direct_check("reset_a", actual(1'b0), 7'b0);
    direct_check("reset_b", actual(1'b1), 7'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full ramp up (edges 0..9), hold ON, ramp down from edge 20.
    steps(3,  0, 1, 0, 4'b0001, 1, 0, 0);
    steps(3,  0, 1, 0, 4'b0011, 1, 0, 0);
    steps(3,  0, 1, 0, 4'b0111, 1, 0, 0);
    steps(11, 0, 1, 0, 4'b1111, 0, 1, 0);
    steps(3,  0, 0, 0, 4'b0111, 1, 0, 0);
    steps(3,  0, 0, 0, 4'b0011, 1, 0, 0);
    steps(3,  0, 0, 0, 4'b0001, 1, 0, 0);
    steps(2,  0, 0, 0, 4'b0000, 0, 0, 0);

    // Reversal: down at edge 4, up at edge 5, next step at edge 8.
    steps(3,  0, 1, 0, 4'b0001, 1, 0, 0);
    step (    0, 1, 0, 4'b0011, 1, 0, 0);
    step (    0, 0, 0, 4'b0001, 1, 0, 0);
    steps(3,  0, 1, 0, 4'b0011, 1, 0, 0);
    step (    0, 1, 0, 4'b0111, 1, 0, 0);
    steps(3,  0, 0, 0, 4'b0011, 1, 0, 0);
    steps(3,  0, 0, 0, 4'b0001, 1, 0, 0);
    steps(2,  0, 0, 0, 4'b0000, 0, 0, 0);

    // Abort during UP while en_in stays high, lockout, then release and restart.
    steps(3,  0, 1, 0, 4'b0001, 1, 0, 0);
    step (    0, 1, 0, 4'b0011, 1, 0, 0);
    step (    0, 1, 1, 4'b0000, 0, 0, 1);
    steps(11, 0, 1, 0, 4'b0000, 0, 0, 1);
    step (    0, 0, 0, 4'b0000, 0, 0, 0);
    steps(3,  0, 1, 0, 4'b0001, 1, 0, 0);
    step (    0, 1, 0, 4'b0011, 1, 0, 0);

    // Asynchronous reset mid-ramp, then restart with en_in still high.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 direct_check("async_reset_a", actual(1'b0), 7'b0);
    @(negedge clk);
    rst = 1'b0;
    step (    0, 1, 0, 4'b0001, 1, 0, 0);
    step (    0, 0, 0, 4'b0000, 0, 0, 0);

    // STAGES=1, GAP=1: en_in 1,1,0,1.
    step(1, 1, 0, 4'b0001, 0, 1, 0);
    step(1, 1, 0, 4'b0001, 0, 1, 0);
    step(1, 0, 0, 4'b0000, 0, 0, 0);
    step(1, 1, 0, 4'b0001, 0, 1, 0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
